// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared constants and next-count function for the JK BCD counter
//
// Contents:
//   WIDTH_DEF        default counter width (bits)
//   MODULUS_DEF      default count modulus (decade counter)
//   load_is_illegal  true when a parallel-load value is outside 0..modulus-1
//   next_count       next counter value from current value and controls
//                    (excludes reset, which the JK cells apply on their own)
package jk_pkg;

    localparam int unsigned WIDTH_DEF   = 4;
    localparam int unsigned MODULUS_DEF = 10;

    function automatic logic load_is_illegal(
        input int unsigned din,
        input int unsigned modulus
    );
        return (din >= modulus);
    endfunction

    // Priority: load > en > hold.
    // An illegal load value forces the count to zero rather than storing an out-of-range code.
    function automatic int unsigned next_count(
        input int unsigned q,
        input int unsigned din,
        input int unsigned modulus,
        input logic        en,
        input logic        up,
        input logic        load
    );
        int unsigned result;
        result = q;
        if (load) begin
            result = load_is_illegal(din, modulus) ? 0 : din;
        end else if (en) begin
            if (up) begin
                result = (q == modulus - 1) ? 0 : q + 1;
            end else begin
                result = (q == 0) ? modulus - 1 : q - 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/jk_bit.sv
// rtl/jk_bit.sv - single JK flip-flop with synchronous active-low reset
//
// Ports:
//   Clk  in   clock, rising-edge
//   rst  in   synchronous reset, active-low (clears Q)
//   J    in   set/toggle input
//   K    in   reset/toggle input
//   Q    out  stored bit
// JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_bit (
    input  logic Clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic r_q;

    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else begin
            case ({J, K})
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/jk_bcd_counter.sv
// rtl/jk_bcd_counter.sv - modulo-N up/down counter built from JK cells, with load and sticky error
//
// Parameters:
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1 (2..2**WIDTH)
// Ports:
//   Clk   in   clock, rising-edge
//   rst   in   synchronous reset, active-low
//   en    in   count enable
//   up    in   direction, 1 = up, 0 = down
//   load  in   parallel load strobe
//   din   in   parallel load value
//   Q     out  registered count
//   tc    out  terminal count / carry-borrow, combinational
//   err   out  sticky illegal-load flag, registered
module jk_bcd_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned MODULUS = MODULUS_DEF
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             err
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_jk;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_illegal;
    logic             r_err;

    always_comb begin
        w_next = WIDTH'(next_count(32'(w_q), 32'(din), MODULUS, en, up, load));
    end

    // Toggle-only excitation: a cell toggles exactly when its bit must change.
    // Reset is not folded in here; each cell clears itself on rst.
    assign w_jk = w_q ^ w_next;

    genvar gi;
    generate
        for (gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
            jk_bit u_bit (
                .Clk (Clk),
                .rst (rst),
                .J   (w_jk[gi]),
                .K   (w_jk[gi]),
                .Q   (w_q[gi])
            );
        end
    endgenerate

    assign w_at_max  = (32'(w_q) == MODULUS - 1);
    assign w_at_zero = (w_q == '0);

    // tc depends only on the current count and controls, so it stays valid during reset.
    assign tc = en & ~load & ((up & w_at_max) | (~up & w_at_zero));

    assign w_illegal = load & load_is_illegal(32'(din), MODULUS);

    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign Q   = w_q;
    assign err = r_err;

endmodule

// File: tb/tb_jk_bcd_counter.sv
// tb/tb_jk_bcd_counter.sv - self-checking bench for jk_bcd_counter
module tb_jk_bcd_counter;

    localparam int M = 10;

    logic       Clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] Q;
    logic       tc;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] din;
        logic       chk_tc;
        logic       exp_tc;
        logic [3:0] exp_q;
        logic       exp_err;
    } vec_t;

    vec_t vq[$];

    jk_bcd_counter #(.WIDTH(4), .MODULUS(M)) dut (
        .Clk  (Clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .Q    (Q),
        .tc   (tc),
        .err  (err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout, got no finish, required finish before limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic e, input logic u, input logic [3:0] d,
                       input logic ct, input logic t, input logic [3:0] q, input logic er);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.up = u; v.din = d;
        v.chk_tc = ct; v.exp_tc = t; v.exp_q = q; v.exp_err = er;
        vq.push_back(v);
    endtask

    // Apply one cycle: drive on the falling edge, check tc before the rising edge,
    // check Q/err shortly after it.
    task automatic apply(input logic r, input logic l, input logic e, input logic u, input logic [3:0] d,
                         input logic ct, input logic t, input logic [3:0] q, input logic er, input string tag);
        @(negedge Clk);
        rst = r; load = l; en = e; up = u; din = d;
        #1;
        if (ct) check({tag, "_tc"}, 32'(tc), 32'(t));
        @(posedge Clk);
        #1;
        check({tag, "_q"}, 32'(Q), 32'(q));
        check({tag, "_err"}, 32'(err), 32'(er));
    endtask

    int m_q;
    logic m_err;

    initial begin
        rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; din = 4'd0;

        // Reset with load asserted
        add(0, 1, 0, 1, 4'd7, 0, 0, 4'd0, 0);
        add(0, 1, 0, 1, 4'd7, 1, 0, 4'd0, 0);
        // Up count 12 edges from 0; tc only while Q=9
        for (int k = 0; k < 12; k++)
            add(1, 0, 1, 1, 4'd0, 1, (k % M) == M - 1, 4'((k + 1) % M), 0);
        // Down count through the 0 -> 9 wrap
        add(1, 1, 0, 0, 4'd2, 1, 0, 4'd2, 0);
        add(1, 0, 1, 0, 4'd0, 1, 0, 4'd1, 0);
        add(1, 0, 1, 0, 4'd0, 1, 0, 4'd0, 0);
        add(1, 0, 1, 0, 4'd0, 1, 1, 4'd9, 0);
        add(1, 0, 1, 0, 4'd0, 1, 0, 4'd8, 0);
        // Illegal load then legal load: err sticks
        add(1, 1, 0, 1, 4'd12, 1, 0, 4'd0, 1);
        add(1, 1, 0, 1, 4'd5, 1, 0, 4'd5, 1);
        // Priority: load beats en at Q=9, tc masked by load
        add(1, 1, 0, 1, 4'd9, 1, 0, 4'd9, 1);
        add(1, 1, 1, 1, 4'd3, 1, 0, 4'd3, 1);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 1, 4'd0, 1, 0, 4'd3, 1);
        // Mid-count reset at Q=6, then resume with no lost edge
        add(1, 1, 0, 1, 4'd4, 1, 0, 4'd4, 1);
        add(1, 0, 1, 1, 4'd0, 1, 0, 4'd5, 1);
        add(1, 0, 1, 1, 4'd0, 1, 0, 4'd6, 1);
        add(0, 0, 1, 1, 4'd0, 1, 0, 4'd0, 0);
        add(1, 0, 1, 1, 4'd0, 1, 0, 4'd1, 0);
        add(1, 0, 1, 1, 4'd0, 1, 0, 4'd2, 0);
        add(1, 0, 1, 1, 4'd0, 1, 0, 4'd3, 0);
        // tc during reset: at Q=0 with en=1, up=0
        add(0, 0, 1, 0, 4'd0, 1, 0, 4'd0, 0);
        add(0, 0, 1, 0, 4'd0, 1, 1, 4'd0, 0);
        // Direction change takes effect on the same edge
        add(1, 0, 1, 1, 4'd0, 1, 0, 4'd1, 0);
        add(1, 0, 1, 0, 4'd0, 1, 0, 4'd0, 0);
        add(1, 0, 1, 0, 4'd0, 1, 1, 4'd9, 0);
        add(1, 0, 1, 1, 4'd0, 1, 1, 4'd0, 0);
        // Largest input value is illegal
        add(1, 1, 1, 0, 4'd15, 1, 0, 4'd0, 1);

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].load, vq[i].en, vq[i].up, vq[i].din,
                  vq[i].chk_tc, vq[i].exp_tc, vq[i].exp_q, vq[i].exp_err,
                  $sformatf("vec%0d", i));
        end

        // Random phase against an arithmetic reference model
        m_q   = int'(vq[vq.size() - 1].exp_q);
        m_err = vq[vq.size() - 1].exp_err;
        for (int n = 0; n < 400; n++) begin
            logic r, l, e, u, t;
            logic [3:0] d;
            r = ($urandom_range(0, 19) != 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            d = 4'($urandom_range(0, 15));
            t = e && !l && ((u && m_q == M - 1) || (!u && m_q == 0));
            if (!r) begin
                m_q = 0; m_err = 1'b0;
            end else if (l) begin
                if (d < M) m_q = int'(d);
                else begin m_q = 0; m_err = 1'b1; end
            end else if (e) begin
                m_q = (m_q + (u ? 1 : M - 1)) % M;
            end
            apply(r, l, e, u, d, 1'b1, t, 4'(m_q), m_err, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
